// File: rtl/rb_access_arbiter.sv
// Two-requester arbiter for the shared register-bank channel: one-entry slot per requester,
// round-robin grant, read-return routing. Optional read timeout under RB_ARB_TIMEOUT_EN.
module rb_access_arbiter #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter int                BMASK_W  = 2,
    parameter int                TIMEOUT  = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = 16'hDEAD
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_rq0_write,
    input  logic               i_rq0_read,
    input  logic [ADDR_W-1:0]  i_rq0_addr,
    input  logic [DATA_W-1:0]  i_rq0_wdata,
    input  logic [BMASK_W-1:0] i_rq0_bmask,
    output logic [DATA_W-1:0]  o_rq0_rdata,
    output logic               o_rq0_rvalid,
    output logic               o_rq0_rerr,
    output logic               o_rq0_busy,
    output logic               o_rq0_drop,
    input  logic               i_rq1_write,
    input  logic               i_rq1_read,
    input  logic [ADDR_W-1:0]  i_rq1_addr,
    input  logic [DATA_W-1:0]  i_rq1_wdata,
    input  logic [BMASK_W-1:0] i_rq1_bmask,
    output logic [DATA_W-1:0]  o_rq1_rdata,
    output logic               o_rq1_rvalid,
    output logic               o_rq1_rerr,
    output logic               o_rq1_busy,
    output logic               o_rq1_drop,
    output logic               o_rb_write,
    output logic [ADDR_W-1:0]  o_rb_waddr,
    output logic [DATA_W-1:0]  o_rb_wdata,
    output logic [BMASK_W-1:0] o_rb_bmask,
    output logic               o_rb_read,
    output logic [ADDR_W-1:0]  o_rb_raddr,
    input  logic               i_rb_rvalid,
    input  logic [DATA_W-1:0]  i_rb_rdata
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    logic [1:0]         w_wr;
    logic [1:0]         w_rd;
    logic [ADDR_W-1:0]  w_addr  [2];
    logic [DATA_W-1:0]  w_wdata [2];
    logic [BMASK_W-1:0] w_bmask [2];
    logic [1:0]         w_outst;
    logic [1:0]         w_busy;
    logic [1:0]         w_cap;
    logic [1:0]         w_drop;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_grant_vld;
    logic               w_grant;
    logic               w_resp_vld;
    logic               w_resp_err;

    logic [1:0]         r_slot_full;
    logic [1:0]         r_slot_wr;
    logic [ADDR_W-1:0]  r_slot_addr  [2];
    logic [DATA_W-1:0]  r_slot_wdata [2];
    logic [BMASK_W-1:0] r_slot_bmask [2];

    logic               r_owner;
    logic               r_last;
    logic [1:0]         r_drop;
    logic [1:0]         r_rvalid;
    logic [DATA_W-1:0]  r_rdata [2];

    logic               r_rb_write;
    logic [ADDR_W-1:0]  r_rb_waddr;
    logic [DATA_W-1:0]  r_rb_wdata;
    logic [BMASK_W-1:0] r_rb_bmask;
    logic               r_rb_read;
    logic [ADDR_W-1:0]  r_rb_raddr;

    assign w_wr       = {i_rq1_write, i_rq0_write};
    assign w_rd       = {i_rq1_read, i_rq0_read};
    assign w_addr[0]  = i_rq0_addr;
    assign w_addr[1]  = i_rq1_addr;
    assign w_wdata[0] = i_rq0_wdata;
    assign w_wdata[1] = i_rq1_wdata;
    assign w_bmask[0] = i_rq0_bmask;
    assign w_bmask[1] = i_rq1_bmask;

    // A requester is busy while its slot holds an access or its read is still in flight.
    assign w_outst[0] = (r_state == ST_RD_WAIT) && (r_owner == 1'b0);
    assign w_outst[1] = (r_state == ST_RD_WAIT) && (r_owner == 1'b1);
    assign w_busy     = r_slot_full | w_outst;
    assign w_cap      = (w_wr | w_rd) & ~w_busy;
    // Read is lost when it collides with a write in the same strobe.
    assign w_drop     = ((w_wr | w_rd) & w_busy) | (w_wr & w_rd);

`ifdef RB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_rerr;

    // Read-wait counter: cleared on read issue, saturates at the limit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_grant_vld && !r_slot_wr[w_grant]) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == ST_RD_WAIT) && (r_cnt != CNT_W'(TIMEOUT))) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Error flag travels with the routed read response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rerr <= 2'b00;
        end else begin
            r_rerr[0] <= w_resp_vld && w_resp_err && (r_owner == 1'b0);
            r_rerr[1] <= w_resp_vld && w_resp_err && (r_owner == 1'b1);
        end
    end

    assign o_rq0_rerr = r_rerr[0];
    assign o_rq1_rerr = r_rerr[1];
`else
    assign o_rq0_rerr = 1'b0;
    assign o_rq1_rerr = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant selection, read completion and next state.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_vld = 1'b0;
        w_grant     = 1'b0;
        w_resp_vld  = 1'b0;
        w_resp_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|r_slot_full) begin
                    w_grant_vld = 1'b1;
                    if (&r_slot_full) begin
                        w_grant = ~r_last;
                    end else begin
                        w_grant = r_slot_full[1];
                    end
                    if (r_slot_wr[w_grant]) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RD_WAIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (i_rb_rvalid) begin
                    w_resp_vld  = 1'b1;
                    w_state_nxt = ST_IDLE;
`ifdef RB_ARB_TIMEOUT_EN
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_resp_vld  = 1'b1;
                    w_resp_err  = 1'b1;
                    w_state_nxt = ST_IDLE;
`endif
                end else begin
                    w_state_nxt = ST_RD_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Per-requester slot capture and release on grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot_full <= 2'b00;
            r_slot_wr   <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                r_slot_addr[k]  <= {ADDR_W{1'b0}};
                r_slot_wdata[k] <= {DATA_W{1'b0}};
                r_slot_bmask[k] <= {BMASK_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_cap[k]) begin
                    r_slot_full[k]  <= 1'b1;
                    r_slot_wr[k]    <= w_wr[k];
                    r_slot_addr[k]  <= w_addr[k];
                    r_slot_wdata[k] <= w_wdata[k];
                    r_slot_bmask[k] <= w_bmask[k];
                end else if (w_grant_vld && (w_grant == 1'(k))) begin
                    r_slot_full[k] <= 1'b0;
                end
            end
        end
    end

    // Regbank issue: strobes last one cycle, address/data hold between issues.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rb_write <= 1'b0;
            r_rb_waddr <= {ADDR_W{1'b0}};
            r_rb_wdata <= {DATA_W{1'b0}};
            r_rb_bmask <= {BMASK_W{1'b0}};
            r_rb_read  <= 1'b0;
            r_rb_raddr <= {ADDR_W{1'b0}};
            r_owner    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_rb_write <= 1'b0;
            r_rb_read  <= 1'b0;
            if (w_grant_vld) begin
                r_last <= w_grant;
                if (r_slot_wr[w_grant]) begin
                    r_rb_write <= 1'b1;
                    r_rb_waddr <= r_slot_addr[w_grant];
                    r_rb_wdata <= r_slot_wdata[w_grant];
                    r_rb_bmask <= r_slot_bmask[w_grant];
                end else begin
                    r_rb_read  <= 1'b1;
                    r_rb_raddr <= r_slot_addr[w_grant];
                    r_owner    <= w_grant;
                end
            end
        end
    end

    // Drop pulses and read-response routing to the owning requester.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop   <= 2'b00;
            r_rvalid <= 2'b00;
            r_rdata[0] <= {DATA_W{1'b0}};
            r_rdata[1] <= {DATA_W{1'b0}};
        end else begin
            r_drop <= w_drop;
            for (int k = 0; k < 2; k++) begin
                r_rvalid[k] <= w_resp_vld && (r_owner == 1'(k));
                if (w_resp_vld && (r_owner == 1'(k))) begin
                    r_rdata[k] <= w_resp_err ? ERR_DATA : i_rb_rdata;
                end
            end
        end
    end

    assign o_rq0_busy   = w_busy[0];
    assign o_rq1_busy   = w_busy[1];
    assign o_rq0_drop   = r_drop[0];
    assign o_rq1_drop   = r_drop[1];
    assign o_rq0_rvalid = r_rvalid[0];
    assign o_rq1_rvalid = r_rvalid[1];
    assign o_rq0_rdata  = r_rdata[0];
    assign o_rq1_rdata  = r_rdata[1];
    assign o_rb_write   = r_rb_write;
    assign o_rb_waddr   = r_rb_waddr;
    assign o_rb_wdata   = r_rb_wdata;
    assign o_rb_bmask   = r_rb_bmask;
    assign o_rb_read    = r_rb_read;
    assign o_rb_raddr   = r_rb_raddr;

endmodule

// File: tb/tb_rb_access_arbiter.sv
// Directed, table-driven bench for rb_access_arbiter; timeout sequences run when
// RB_ARB_TIMEOUT_EN is defined.
module tb_rb_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr0, rd0, wr1, rd1, rbv;
    logic [7:0]  a0, a1;
    logic [15:0] d0, d1, rbd;
    logic [1:0]  bm0, bm1;
    logic [15:0] rq0_rdata, rq1_rdata, rb_wdata;
    logic        rq0_rvalid, rq1_rvalid, rq0_rerr, rq1_rerr;
    logic        rq0_busy, rq1_busy, rq0_drop, rq1_drop;
    logic        rb_write, rb_read;
    logic [7:0]  rb_waddr, rb_raddr;
    logic [1:0]  rb_bmask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rb_access_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rq0_write(wr0), .i_rq0_read(rd0), .i_rq0_addr(a0), .i_rq0_wdata(d0), .i_rq0_bmask(bm0),
        .o_rq0_rdata(rq0_rdata), .o_rq0_rvalid(rq0_rvalid), .o_rq0_rerr(rq0_rerr),
        .o_rq0_busy(rq0_busy), .o_rq0_drop(rq0_drop),
        .i_rq1_write(wr1), .i_rq1_read(rd1), .i_rq1_addr(a1), .i_rq1_wdata(d1), .i_rq1_bmask(bm1),
        .o_rq1_rdata(rq1_rdata), .o_rq1_rvalid(rq1_rvalid), .o_rq1_rerr(rq1_rerr),
        .o_rq1_busy(rq1_busy), .o_rq1_drop(rq1_drop),
        .o_rb_write(rb_write), .o_rb_waddr(rb_waddr), .o_rb_wdata(rb_wdata), .o_rb_bmask(rb_bmask),
        .o_rb_read(rb_read), .o_rb_raddr(rb_raddr),
        .i_rb_rvalid(rbv), .i_rb_rdata(rbd)
    );

    typedef struct {
        logic wr0; logic rd0; logic [7:0] a0; logic [15:0] d0; logic [1:0] bm0;
        logic wr1; logic rd1; logic [7:0] a1; logic [15:0] d1; logic [1:0] bm1;
        logic rbv; logic [15:0] rbd;
        logic e_w; logic e_r; logic [7:0] e_wa; logic [15:0] e_wd; logic [1:0] e_bm; logic [7:0] e_ra;
        logic [1:0] e_busy; logic [1:0] e_drop; logic [1:0] e_rv; logic [1:0] e_rerr;
        logic [15:0] e_rd0; logic [15:0] e_rd1;
    } vec_t;

    vec_t vec [31];

    function automatic logic [79:0] outs();
        return 80'({rb_write, rb_read, rb_waddr, rb_wdata, rb_bmask, rb_raddr,
                    rq1_busy, rq0_busy, rq1_drop, rq0_drop, rq1_rvalid, rq0_rvalid,
                    rq1_rerr, rq0_rerr, rq0_rdata, rq1_rdata});
    endfunction

    function automatic logic [79:0] expv(input vec_t v);
        return 80'({v.e_w, v.e_r, v.e_wa, v.e_wd, v.e_bm, v.e_ra, v.e_busy, v.e_drop,
                    v.e_rv, v.e_rerr, v.e_rd0, v.e_rd1});
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr0 = 1'b0; rd0 = 1'b0; a0 = 8'h00; d0 = 16'h0000; bm0 = 2'b00;
        wr1 = 1'b0; rd1 = 1'b0; a1 = 8'h00; d1 = 16'h0000; bm1 = 2'b00;
        rbv = 1'b0; rbd = 16'h0000;
    endtask

    task automatic apply(input vec_t v);
        wr0 = v.wr0; rd0 = v.rd0; a0 = v.a0; d0 = v.d0; bm0 = v.bm0;
        wr1 = v.wr1; rd1 = v.rd1; a1 = v.a1; d1 = v.d1; bm1 = v.bm1;
        rbv = v.rbv; rbd = v.rbd;
    endtask

    task automatic wait_rb_read(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rb_read) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk(name, 80'(seen), 80'd1);
    endtask

    initial begin
        // One row per cycle: inputs driven this cycle, outputs observed this cycle.
        vec[0]  = '{1'b1,1'b0,8'h12,16'hBEEF,2'b11, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h00,16'h0000,2'b00,8'h00,2'b00,2'b00,2'b00,2'b00,16'h0000,16'h0000};
        vec[1]  = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h00,16'h0000,2'b00,8'h00,2'b01,2'b00,2'b00,2'b00,16'h0000,16'h0000};
        vec[2]  = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b1,1'b0,8'h12,16'hBEEF,2'b11,8'h00,2'b00,2'b00,2'b00,2'b00,16'h0000,16'h0000};
        vec[3]  = '{1'b0,1'b1,8'h05,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h12,16'hBEEF,2'b11,8'h00,2'b00,2'b00,2'b00,2'b00,16'h0000,16'h0000};
        vec[4]  = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h12,16'hBEEF,2'b11,8'h00,2'b01,2'b00,2'b00,2'b00,16'h0000,16'h0000};
        vec[5]  = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b1,8'h12,16'hBEEF,2'b11,8'h05,2'b01,2'b00,2'b00,2'b00,16'h0000,16'h0000};
        vec[6]  = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h12,16'hBEEF,2'b11,8'h05,2'b01,2'b00,2'b00,2'b00,16'h0000,16'h0000};
        vec[7]  = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h12,16'hBEEF,2'b11,8'h05,2'b01,2'b00,2'b00,2'b00,16'h0000,16'h0000};
        vec[8]  = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b1,16'h1234, 1'b0,1'b0,8'h12,16'hBEEF,2'b11,8'h05,2'b01,2'b00,2'b00,2'b00,16'h0000,16'h0000};
        vec[9]  = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h12,16'hBEEF,2'b11,8'h05,2'b00,2'b00,2'b01,2'b00,16'h1234,16'h0000};
        vec[10] = '{1'b1,1'b0,8'h20,16'h1111,2'b01, 1'b1,1'b0,8'h21,16'h2222,2'b10, 1'b0,16'h0000, 1'b0,1'b0,8'h12,16'hBEEF,2'b11,8'h05,2'b00,2'b00,2'b00,2'b00,16'h1234,16'h0000};
        vec[11] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h12,16'hBEEF,2'b11,8'h05,2'b11,2'b00,2'b00,2'b00,16'h1234,16'h0000};
        vec[12] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b1,1'b0,8'h21,16'h2222,2'b10,8'h05,2'b01,2'b00,2'b00,2'b00,16'h1234,16'h0000};
        vec[13] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b1,1'b0,8'h20,16'h1111,2'b01,8'h05,2'b00,2'b00,2'b00,2'b00,16'h1234,16'h0000};
        vec[14] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b1,1'b0,8'h40,16'h5555,2'b11, 1'b0,16'h0000, 1'b0,1'b0,8'h20,16'h1111,2'b01,8'h05,2'b00,2'b00,2'b00,2'b00,16'h1234,16'h0000};
        vec[15] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h20,16'h1111,2'b01,8'h05,2'b10,2'b00,2'b00,2'b00,16'h1234,16'h0000};
        vec[16] = '{1'b1,1'b0,8'h30,16'h3333,2'b11, 1'b1,1'b0,8'h31,16'h4444,2'b10, 1'b0,16'h0000, 1'b1,1'b0,8'h40,16'h5555,2'b11,8'h05,2'b00,2'b00,2'b00,2'b00,16'h1234,16'h0000};
        vec[17] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h40,16'h5555,2'b11,8'h05,2'b11,2'b00,2'b00,2'b00,16'h1234,16'h0000};
        vec[18] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b1,1'b0,8'h30,16'h3333,2'b11,8'h05,2'b10,2'b00,2'b00,2'b00,16'h1234,16'h0000};
        vec[19] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b1,1'b0,8'h31,16'h4444,2'b10,8'h05,2'b00,2'b00,2'b00,2'b00,16'h1234,16'h0000};
        vec[20] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b1,8'h50,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h31,16'h4444,2'b10,8'h05,2'b00,2'b00,2'b00,2'b00,16'h1234,16'h0000};
        vec[21] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h31,16'h4444,2'b10,8'h05,2'b10,2'b00,2'b00,2'b00,16'h1234,16'h0000};
        vec[22] = '{1'b1,1'b0,8'h52,16'h7777,2'b01, 1'b1,1'b0,8'h51,16'h6666,2'b11, 1'b0,16'h0000, 1'b0,1'b1,8'h31,16'h4444,2'b10,8'h50,2'b10,2'b00,2'b00,2'b00,16'h1234,16'h0000};
        vec[23] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b1,8'h53,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h31,16'h4444,2'b10,8'h50,2'b11,2'b10,2'b00,2'b00,16'h1234,16'h0000};
        vec[24] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b1,16'hABCD, 1'b0,1'b0,8'h31,16'h4444,2'b10,8'h50,2'b11,2'b10,2'b00,2'b00,16'h1234,16'h0000};
        vec[25] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h31,16'h4444,2'b10,8'h50,2'b01,2'b00,2'b10,2'b00,16'h1234,16'hABCD};
        vec[26] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b1,1'b0,8'h52,16'h7777,2'b01,8'h50,2'b00,2'b00,2'b00,2'b00,16'h1234,16'hABCD};
        vec[27] = '{1'b1,1'b1,8'h60,16'h8888,2'b10, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h52,16'h7777,2'b01,8'h50,2'b00,2'b00,2'b00,2'b00,16'h1234,16'hABCD};
        vec[28] = '{1'b1,1'b0,8'h70,16'h9999,2'b11, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h52,16'h7777,2'b01,8'h50,2'b01,2'b01,2'b00,2'b00,16'h1234,16'hABCD};
        vec[29] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b1,16'hFFFF, 1'b1,1'b0,8'h60,16'h8888,2'b10,8'h50,2'b00,2'b01,2'b00,2'b00,16'h1234,16'hABCD};
        vec[30] = '{1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,1'b0,8'h00,16'h0000,2'b00, 1'b0,16'h0000, 1'b0,1'b0,8'h60,16'h8888,2'b10,8'h50,2'b00,2'b00,2'b00,2'b00,16'h1234,16'hABCD};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 80'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            apply(vec[i]);
            chk($sformatf("row%0d", i), outs(), expv(vec[i]));
            step();
        end
        idle_inputs();
        step();

`ifdef RB_ARB_TIMEOUT_EN
        // Read with no regbank answer: error response 16 cycles after issue.
        rd1 = 1'b1; a1 = 8'h77;
        step();
        idle_inputs();
        wait_rb_read("to_issue");
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k < 16) begin
                chk($sformatf("to_quiet%0d", k), 80'(rq1_rvalid), 80'd0);
            end else begin
                chk("to_resp", 80'({rq1_rvalid, rq1_rerr, rq1_rdata, rq0_rvalid}),
                    80'({1'b1, 1'b1, 16'hDEAD, 1'b0}));
                rbv = 1'b1; rbd = 16'h4321;
            end
        end
        step();
        idle_inputs();
        chk("to_late_ignored", 80'({rq1_rvalid, rq0_rvalid, rq1_rdata}), 80'({2'b00, 16'hDEAD}));
        // Regbank answer on the limit cycle wins over the timeout.
        rd1 = 1'b1; a1 = 8'h78;
        step();
        idle_inputs();
        wait_rb_read("to_edge_issue");
        for (int k = 1; k <= 16; k++) begin
            step();
            rbv = 1'b0;
            if (k == 15) begin
                rbv = 1'b1; rbd = 16'h5A5A;
            end
            if (k == 16) begin
                chk("to_edge_resp", 80'({rq1_rvalid, rq1_rerr, rq1_rdata}),
                    80'({1'b1, 1'b0, 16'h5A5A}));
            end
        end
        idle_inputs();
        step();
`endif

        // Reset while a read is outstanding: no response afterwards.
        rd0 = 1'b1; a0 = 8'h88;
        step();
        idle_inputs();
        wait_rb_read("rst_issue");
        step();
        step();
        chk("rst_busy_before", 80'(rq0_busy), 80'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_read_outputs", outs(), 80'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rbv = 1'b1; rbd = 16'h1111;
        step();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_no_resp%0d", k),
                80'({rq0_rvalid, rq1_rvalid, rb_read, rq0_busy, rq0_rdata}), 80'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
